mem_access_unit: RTL

//  Memory-access stage directly downstream of the ALU. The ALU result is the effective address.

---
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Purpose : memory-access stage; runs LB/LBU/LH/LHU/LW/SB/SH/SW as one req/ack transaction.
// Latency : start at cycle 0, mem_req_o from cycle 1, ack at cycle k, done_o at cycle k+1.
// Backpr. : busy_o stalls the controller; start_i ignored while busy; waits up to TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, op_i[2:0]    request and opcode (000 LB,001 LBU,010 LH,011 LHU,100 LW,101 SB,110 SH,111 SW)
//   addr_i, wdata_i       effective address and store data, latched on start
//   busy_o, done_o        busy in ACCESS/DONE (and trap cycle), 1-cycle done pulse
//   rdata_out_o           extended load result, held until the next done
//   addr_err_o, bus_err_o misalignment / timeout flags, valid with done, cleared on next start
//   mem_req_o .. mem_wdata_o  memory request side, stable while mem_req_o is high
//   mem_rdata_i, mem_ack_i    memory response, 1-cycle ack
//
// Optional feature: define UNALIGNED_TRAP_EN to trap misaligned halfword/word accesses
// (no memory request, addr_err_o set, done two cycles after start).
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_out_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  // counter holds 0..TIMEOUT-1; expiry when the last ACCESS cycle passes without ack
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAP   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              aerr_q, aerr_d;
  logic              berr_q, berr_d;

  logic              we_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic              trap_c;
  logic [31:0]       load_c;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // request-side decode from the raw inputs, captured on start
  always_comb begin
    we_c    = op_i[2] & (op_i[1] | op_i[0]);
    be_c    = 4'b1111;
    wdata_c = wdata_i;
    case (op_i)
      3'b101: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      3'b110: begin
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef UNALIGNED_TRAP_EN
  always_comb begin
    case (op_i)
      3'b010, 3'b011, 3'b110: trap_c = addr_i[0];
      3'b100, 3'b111:         trap_c = |addr_i[1:0];
      default:                trap_c = 1'b0;
    endcase
  end
`else
  assign trap_c = 1'b0;
`endif

  // load extraction from the acked word, lane taken from the latched address
  always_comb begin
    ld_byte = mem_rdata_i[8*lane_q +: 8];
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      3'b000:  load_c = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_c = {24'd0, ld_byte};
      3'b010:  load_c = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_c = {16'd0, ld_half};
      default: load_c = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lane_d   = lane_q;
    req_d    = req_q;
    we_d     = we_q;
    be_d     = be_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    aerr_d   = aerr_q;
    berr_d   = berr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d     = op_i;
          lane_d   = addr_i[1:0];
          we_d     = we_c;
          be_d     = be_c;
          maddr_d  = {addr_i[31:2], 2'b00};
          mwdata_d = wdata_c;
          cnt_d    = '0;
          aerr_d   = trap_c;
          berr_d   = 1'b0;
          if (trap_c) begin
            rdata_d = 32'd0;
            state_d = S_TRAP;
          end else begin
            req_d   = 1'b1;
            state_d = S_ACCESS;
          end
        end
      end
      // one dead cycle so a trapped access still completes two cycles after start
      S_TRAP: state_d = S_DONE;
      S_ACCESS: begin
        // ack takes priority over an expiry in the same cycle
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) rdata_d = load_c;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          rdata_d = 32'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      lane_q   <= 2'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      cnt_q    <= '0;
      rdata_q  <= 32'd0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lane_q   <= lane_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      aerr_q   <= aerr_d;
      berr_q   <= berr_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign rdata_out_o = rdata_q;
  assign addr_err_o  = aerr_q;
  assign bus_err_o   = berr_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;

endmodule
